// File: rtl/ram_sync_init_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_sync_init_if
// Description : Access bus for ram_sync_init. The master issues select/write/
//               init_req; the slave returns registered read data, a read
//               valid strobe and the clear-sequencer busy flag.
//               parity_err exists only when RAM_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_sync_init_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              select;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              init_req;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              busy;
`ifdef RAM_PARITY_EN
  logic              parity_err;

  modport master (
    output select, write, address, data_in, init_req,
    input  data_out, rd_valid, busy, parity_err
  );

  modport slave (
    input  select, write, address, data_in, init_req,
    output data_out, rd_valid, busy, parity_err
  );
`else
  modport master (
    output select, write, address, data_in, init_req,
    input  data_out, rd_valid, busy
  );

  modport slave (
    input  select, write, address, data_in, init_req,
    output data_out, rd_valid, busy
  );
`endif
endinterface
`default_nettype wire

// File: rtl/ram_sync_init.sv
`default_nettype none
// ============================================================================
// Module      : ram_sync_init
// Description : Single-port synchronous RAM with 1-cycle registered reads, a
//               read-valid strobe and a hardware clear sequencer that writes
//               INIT_VAL to every word after reset or on init_req.
//               Optional feature macro: RAM_PARITY_EN (per-word even parity
//               bit and a registered parity_err flag on reads).
// Revision    : 1.0 - initial release
// ============================================================================
module ram_sync_init #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 10,
  parameter int                DEPTH    = 1024,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input wire             clk,
  input wire             rst_n,
  ram_sync_init_if.slave bus
);

`ifdef RAM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   c_depth_ext = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_IDLE = 1'b1;

  // Stored word layout: {parity, data} with parity, or just data without.
  function automatic logic [WORD_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef RAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [WORD_W-1:0] mem [DEPTH];

  logic              in_range;
  logic              idle_ok;
  logic              user_wr;
  logic              user_rd;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;

  logic [DATA_W-1:0] data_out_q;
  logic              rd_valid_q;

  // Accesses are honoured only in IDLE and only when no clear is requested;
  // init_req wins over a same-cycle access, which is simply dropped.
  assign in_range = ({1'b0, bus.address} < c_depth_ext);
  assign idle_ok  = (state == S_IDLE) && !bus.init_req;
  assign user_wr  = idle_ok && bus.select && bus.write && in_range;
  assign user_rd  = idle_ok && bus.select && !bus.write;

  // Out-of-range reads return the clear value instead of touching the array.
  assign rd_word  = in_range ? mem[bus.address] : encode(INIT_VAL);

  // Write port mux: the clear sequencer owns the port while in INIT.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.address;
    wr_word = encode(bus.data_in);
    if (state == S_INIT) begin
      wr_en   = 1'b1;
      wr_addr = clr_cnt;
      wr_word = encode(INIT_VAL);
    end else if (user_wr) begin
      wr_en   = 1'b1;
    end
  end

  // Storage array; contents are deliberately not reset, the sequencer clears them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
  end

  // Clear sequencer: walk 0..DEPTH-1 once, then park in IDLE until init_req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_INIT;
      clr_cnt <= '0;
    end else begin
      case (state)
        S_INIT: begin
          if (clr_cnt == c_last_addr) begin
            state <= S_IDLE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (bus.init_req) begin
            clr_cnt <= '0;
            state   <= S_INIT;
          end
        end
        default: begin
          clr_cnt <= '0;
          state   <= S_INIT;
        end
      endcase
    end
  end

  // Registered read path: data_out holds between reads, rd_valid pulses once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= user_rd;
      if (user_rd) begin
        data_out_q <= rd_word[DATA_W-1:0];
      end
    end
  end

`ifdef RAM_PARITY_EN
  logic parity_err_q;

  // Parity flag follows rd_valid; out-of-range reads never flag an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= user_rd && in_range && (^rd_word);
    end
  end

  assign bus.parity_err = parity_err_q;
`endif

  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = (state == S_INIT);

endmodule
`default_nettype wire

// File: tb/tb_ram_sync_init.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_sync_init
// Description : Directed self-checking bench for ram_sync_init. Instance A is
//               1024x8 with INIT_VAL=0, instance B is 1000x8 with INIT_VAL=5A
//               to exercise out-of-range accesses and a short clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_sync_init;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb_q [$];

  ram_sync_init_if #(.DATA_W(8), .ADDR_W(10)) bus_a ();
  ram_sync_init_if #(.DATA_W(8), .ADDR_W(10)) bus_b ();

  ram_sync_init #(
    .DATA_W  (8),
    .ADDR_W  (10),
    .DEPTH   (1024),
    .INIT_VAL(8'h00)
  ) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_a)
  );

  ram_sync_init #(
    .DATA_W  (8),
    .ADDR_W  (10),
    .DEPTH   (1000),
    .INIT_VAL(8'h5A)
  ) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic deselect();
    bus_a.select = 1'b0; bus_a.write = 1'b0; bus_a.init_req = 1'b0;
    bus_b.select = 1'b0; bus_b.write = 1'b0; bus_b.init_req = 1'b0;
  endtask

  task automatic wr(input bit b, input logic [9:0] a, input logic [7:0] d);
    if (!b) begin
      bus_a.select = 1'b1; bus_a.write = 1'b1; bus_a.address = a; bus_a.data_in = d;
    end else begin
      bus_b.select = 1'b1; bus_b.write = 1'b1; bus_b.address = a; bus_b.data_in = d;
    end
    tick();
    deselect();
  endtask

  // Read: expected data goes to the scoreboard at issue, popped on rd_valid.
  task automatic rd(input bit b, input logic [9:0] a, input logic [7:0] exp, input bit chk_fall);
    logic       v;
    logic [7:0] d;
    logic [7:0] e;
    if (!b) begin
      bus_a.select = 1'b1; bus_a.write = 1'b0; bus_a.address = a;
    end else begin
      bus_b.select = 1'b1; bus_b.write = 1'b0; bus_b.address = a;
    end
    sb_q.push_back(exp);
    tick();
    v = b ? bus_b.rd_valid : bus_a.rd_valid;
    d = b ? bus_b.data_out : bus_a.data_out;
    check("rd_valid", {31'd0, v}, 32'd1);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
    check("rd_data", {24'd0, d}, {24'd0, e});
`ifdef RAM_PARITY_EN
    check("parity_err", {31'd0, (b ? bus_b.parity_err : bus_a.parity_err)}, 32'd0);
`endif
    deselect();
    if (chk_fall) begin
      tick();
      v = b ? bus_b.rd_valid : bus_a.rd_valid;
      check("rd_valid_fall", {31'd0, v}, 32'd0);
    end
  endtask

  // Counts cycles until A leaves INIT; also records when B leaves INIT.
  task automatic count_busy(output int na, output int nb);
    na = 0;
    nb = 0;
    do begin
      tick();
      na++;
      if (!bus_b.busy && nb == 0) nb = na;
    end while (bus_a.busy && na < 3000);
  endtask

  initial begin
    int         na, nb;
    int         a;
    logic       seen_valid;
    logic [9:0] addr;

    rst_n = 1'b0;
    bus_a.address = '0; bus_a.data_in = '0;
    bus_b.address = '0; bus_b.data_in = '0;
    deselect();
    tick();
    tick();

    // Reset state
    check("rst_busy",     {31'd0, bus_a.busy},     32'd1);
    check("rst_rd_valid", {31'd0, bus_a.rd_valid}, 32'd0);
    check("rst_data_out", {24'd0, bus_a.data_out}, 32'd0);
`ifdef RAM_PARITY_EN
    check("rst_parity",   {31'd0, bus_a.parity_err}, 32'd0);
`endif

    // Scenario 1: clear sweep length after release, then cleared reads
    rst_n = 1'b1;
    count_busy(na, nb);
    check("init_cycles_a", na, 32'd1024);
    check("init_cycles_b", nb, 32'd1000);
    rd(0, 10'd0,    8'h00, 1'b0);
    rd(0, 10'd511,  8'h00, 1'b0);
    rd(0, 10'd1023, 8'h00, 1'b1);

    // Scenario 2: fill with 2k, read 20 pseudo-random addresses
    for (int k = 0; k < 1024; k++) begin
      wr(0, 10'(k), 8'((2 * k) % 256));
    end
    a = $urandom(35);
    for (int i = 0; i < 20; i++) begin
      addr = 10'($urandom_range(0, 1023));
      rd(0, addr, 8'((2 * int'(addr)) % 256), 1'b1);
    end

    // Scenario 3: read-after-write in the very next cycle
    wr(0, 10'd7, 8'hA5);
    rd(0, 10'd7, 8'hA5, 1'b1);

    // Scenario 4: init_req beats a same-cycle write
    bus_a.init_req = 1'b1;
    bus_a.select   = 1'b1; bus_a.write = 1'b1;
    bus_a.address  = 10'd3; bus_a.data_in = 8'hFF;
    tick();
    deselect();
    check("reinit_busy", {31'd0, bus_a.busy}, 32'd1);
    na = 0;
    do begin
      tick();
      na++;
    end while (bus_a.busy && na < 3000);
    check("reinit_cycles", na, 32'd1024);
    rd(0, 10'd3, 8'h00, 1'b0);
    rd(0, 10'd7, 8'h00, 1'b1);

    // Scenario 5: reset in the middle of a clear sweep
    wr(0, 10'd9, 8'h3C);
    rd(0, 10'd9, 8'h3C, 1'b0);
    bus_a.init_req = 1'b1;
    tick();
    deselect();
    // Reads issued during INIT must be ignored and data_out must hold.
    bus_a.select = 1'b1; bus_a.write = 1'b0; bus_a.address = 10'd9;
    seen_valid = 1'b0;
    for (int i = 0; i < 299; i++) begin
      tick();
      if (bus_a.rd_valid) seen_valid = 1'b1;
    end
    deselect();
    check("init_no_rd_valid", {31'd0, seen_valid}, 32'd0);
    check("init_hold_data",   {24'd0, bus_a.data_out}, 32'h3C);
    rst_n = 1'b0;
    tick();
    tick();
    check("midrst_busy",     {31'd0, bus_a.busy},     32'd1);
    check("midrst_data_out", {24'd0, bus_a.data_out}, 32'd0);
    check("midrst_rd_valid", {31'd0, bus_a.rd_valid}, 32'd0);
    rst_n = 1'b1;
    count_busy(na, nb);
    check("rst_init_cycles_a", na, 32'd1024);
    check("rst_init_cycles_b", nb, 32'd1000);

    // Scenario 6: DEPTH=1000 instance, last word and out-of-range accesses
    rd(1, 10'd999, 8'h5A, 1'b0);
    wr(1, 10'd999, 8'h77);
    rd(1, 10'd999, 8'h77, 1'b0);
    wr(1, 10'd1010, 8'h55);
    rd(1, 10'd1010, 8'h5A, 1'b0);
    rd(1, 10'd1000, 8'h5A, 1'b0);
    rd(1, 10'd986,  8'h5A, 1'b1);

    check("sb_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_sync_init.md
Name: ram_sync_init

Overview:
Parametrised single-port synchronous RAM, the clocked successor to the 1024x8 asynchronous select/write RAM.
- Adds generic width and depth, registered reads with a valid strobe, and a hardware clear sequencer.
- The sequencer writes INIT_VAL to every location after reset or on request.
- Serves as the scratch and buffer memory for datapath blocks needing a known-initialised store.

Parameters:
DATA_W, 8, word width in bits
ADDR_W, 10, address width in bits
DEPTH, 1024, number of words; legal range 2..2**ADDR_W
INIT_VAL, 0, value written to every word by the clear sequencer (DATA_W bits)

Ports:
clk  input  1  single clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
select  input  1  access request, sampled on clk edge
write  input  1  1 = write, 0 = read; qualified by select
address  input  ADDR_W  word address
data_in  input  DATA_W  write data
init_req  input  1  single-cycle request to re-clear the whole array
data_out  output  DATA_W  registered read data
rd_valid  output  1  one-cycle pulse: data_out updated this cycle
busy  output  1  clear sequencer active; accesses are ignored
parity_err  output  1  read word failed parity check (RAM_PARITY_EN only, else absent)

Behaviour:
- Reset (rst_n=0, async): FSM=INIT, clear counter=0, data_out=0, rd_valid=0, busy=1, parity_err=0. Array contents are not reset directly.
- FSM states: INIT, IDLE.
- INIT:
  - Each cycle writes INIT_VAL to mem[counter], then increments counter.
  - At counter==DEPTH-1 the final write occurs and FSM moves to IDLE on the same edge.
  - Clearing takes exactly DEPTH cycles after reset release.
  - busy=1 throughout INIT; busy falls on the edge entering IDLE.
- During INIT:
  - select, write and init_req are ignored; no re-start of the sequence.
  - rd_valid stays 0.
  - data_out holds its value.
- IDLE, init_req=1: counter<=0, FSM<=INIT, busy<=1 next cycle. init_req has priority over a same-cycle select; that access is dropped.
- IDLE, select=1, write=1: mem[address]<=data_in at the edge. No read and no rd_valid.
- IDLE, select=1, write=0:
  - data_out<=mem[address] at the edge and rd_valid=1 for exactly that following cycle.
  - Read latency is 1 clock.
- IDLE, select=0: no access; rd_valid=0; data_out holds the last read value.
- Read-after-write: a read of an address in the cycle after it was written returns the new data.
- Out of range (address>=DEPTH): the write is discarded; a read returns INIT_VAL with rd_valid=1.
- Reset asserted mid-INIT or mid-access: the sequence restarts from counter 0 after release. An in-flight write at the reset edge is not guaranteed.
- Counter is ADDR_W wide and never wraps past DEPTH-1.

Optional Feature:
RAM_PARITY_EN
- Defined:
  - Each word stores one extra even-parity bit computed from data_in on writes and from INIT_VAL during INIT.
  - On reads, parity_err is registered alongside data_out. It is 1 for the rd_valid cycle if the stored parity mismatches the stored data, else 0.
  - parity_err is 0 whenever rd_valid=0.
  - Out-of-range reads give parity_err=0.
- Undefined: no parity storage and no parity_err port. Behaviour is otherwise identical.

Test Plan:
1. Release rst_n, DEPTH=1024 -> busy=1 for exactly 1024 cycles then 0; reads of addresses 0, 511 and 1023 return INIT_VAL=0 with rd_valid pulse.
2. Write data_in=(2k)%256 to k=0..1023, then read 20 random addresses (seed 35) -> data_out==(2*addr)%256 one cycle after each read, rd_valid high exactly one cycle each.
3. Write 8'hA5 to address 7, read address 7 in the next cycle -> data_out=8'hA5 on the following cycle.
4. After filling the array, pulse init_req together with a write to address 3 -> the write is dropped; busy=1 for 1024 cycles; a subsequent read of address 3 returns 0.
5. Assert rst_n=0 at clear count 300 for 2 cycles -> outputs return to reset values; after release busy lasts the full 1024 cycles again.
6. With DEPTH=1000, ADDR_W=10: write 8'h55 to address 1010, then read it -> no write occurs; the read returns INIT_VAL and rd_valid=1. With RAM_PARITY_EN defined, all reads in scenario 2 give parity_err=0.
